// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

    // Bits needed to hold a counter that runs from 0 up to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester (fetch / load-store) and memory-side signal bundle of the arbiter.
interface mem_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              i_req_i;
    logic [AWIDTH-1:0] i_addr_i;
    logic              i_gnt_o;
    logic              i_rvalid_o;
    logic [DWIDTH-1:0] i_rdata_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [AWIDTH-1:0] d_addr_i;
    logic [DWIDTH-1:0] d_wdata_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [DWIDTH-1:0] d_rdata_o;

    logic [AWIDTH-1:0] mem_addr_o;
    logic [DWIDTH-1:0] mem_data_o;
    logic              mem_read_en_o;
    logic              mem_write_en_o;
    logic [DWIDTH-1:0] mem_data_i;

    // Arbiter side.
    modport slave (
        input  i_req_i, i_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_data_i,
        output i_gnt_o, i_rvalid_o, i_rdata_o,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
    );

    // Requesters plus memory.
    modport master (
        output i_req_i, i_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_data_i,
        input  i_gnt_o, i_rvalid_o, i_rdata_o,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
    );

endinterface

// File: rtl/mem_arb_prio.sv
// Fetch/data priority select with a starvation guard for the fetch port.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_ok,
    input  logic i_req,
    input  logic d_req,
    output logic i_gnt,
    output logic d_gnt
);

    localparam int SW = cnt_width(STARVE_MAX);

    logic [SW-1:0] starve_cnt;
    logic          i_forced;

    // Data wins by default; fetch wins when alone or once starved long enough.
    always_comb begin
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        i_forced = (starve_cnt == SW'(STARVE_MAX));
        if (grant_ok) begin
            if (i_req && (i_forced || !d_req)) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Count consecutive denied fetch cycles, saturating at STARVE_MAX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (i_gnt) begin
            starve_cnt <= '0;
        end else if (i_req && !i_forced) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam int CW = cnt_width(MEM_LAT);

    state_e        state, state_nxt;
    owner_e        owner, owner_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          pend, pend_nxt;

    logic grant_ok;
    logic i_gnt, d_gnt;
    logic rd_gnt;
    logic rsp_due;

    // Grants only in IDLE; gated by reset so the combinational path stays quiet.
    assign grant_ok = rst && (state == IDLE);
    assign rd_gnt   = i_gnt || (d_gnt && !bus.d_we_i);
    // Pending read completes on the first IDLE cycle after its grant.
    assign rsp_due  = pend && (state == IDLE);

    mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .grant_ok(grant_ok),
        .i_req   (bus.i_req_i),
        .d_req   (bus.d_req_i),
        .i_gnt   (i_gnt),
        .d_gnt   (d_gnt)
    );

    // State, owner tag, countdown and pending-read register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= OWN_I;
            wait_cnt <= '0;
            pend     <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            wait_cnt <= wait_cnt_nxt;
            pend     <= pend_nxt;
        end
    end

    // Next state: a read grant arms the response; WAIT burns MEM_LAT-1 cycles.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        wait_cnt_nxt = wait_cnt;
        pend_nxt     = pend;
        case (state)
            IDLE: begin
                pend_nxt = rd_gnt;
                if (rd_gnt) begin
                    owner_nxt = i_gnt ? OWN_I : OWN_D;
                    if (MEM_LAT > 1) begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = CW'(MEM_LAT - 1);
                    end
                end
            end
            WAIT: begin
                if (wait_cnt <= CW'(1)) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Requester-facing outputs and memory drive from the current winner.
    always_comb begin
        bus.i_gnt_o        = i_gnt;
        bus.d_gnt_o        = d_gnt;
        bus.i_rvalid_o     = rsp_due && (owner == OWN_I);
        bus.d_rvalid_o     = rsp_due && (owner == OWN_D);
        bus.i_rdata_o      = rst ? bus.mem_data_i : '0;
        bus.d_rdata_o      = rst ? bus.mem_data_i : '0;
        bus.mem_addr_o     = '0;
        bus.mem_data_o     = '0;
        bus.mem_read_en_o  = 1'b0;
        bus.mem_write_en_o = 1'b0;
        if (i_gnt) begin
            bus.mem_addr_o    = bus.i_addr_i;
            bus.mem_read_en_o = 1'b1;
        end else if (d_gnt) begin
            bus.mem_addr_o = bus.d_addr_i;
            if (bus.d_we_i) begin
                bus.mem_data_o     = bus.d_wdata_i;
                bus.mem_write_en_o = 1'b1;
            end else begin
                bus.mem_read_en_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_mem_arbiter;

    logic clk;
    logic rst1;
    logic rst3;
    int   checks;
    int   errors;

    mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus1 ();
    mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus3 ();

    mem_arbiter #(
        .AWIDTH(32), .DWIDTH(32), .MEM_LAT(1), .STARVE_MAX(4)
    ) u_dut1 (
        .clk(clk), .rst(rst1), .bus(bus1)
    );

    mem_arbiter #(
        .AWIDTH(32), .DWIDTH(32), .MEM_LAT(3), .STARVE_MAX(4)
    ) u_dut3 (
        .clk(clk), .rst(rst3), .bus(bus3)
    );

    always #5 clk = ~clk;

    // Memory models: word array indexed by addr[7:2], read pipeline MEM_LAT deep.
    logic [31:0] mem1 [0:63];
    logic [31:0] mem3 [0:63];
    logic [31:0] pipe1 = 32'hCAFE_F00D;
    logic [31:0] pipe3 [0:2] = '{32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D};

    assign bus1.mem_data_i = pipe1;
    assign bus3.mem_data_i = pipe3[2];

    always @(posedge clk) begin
        if (bus1.mem_write_en_o) mem1[bus1.mem_addr_o[7:2]] <= bus1.mem_data_o;
        if (bus1.mem_read_en_o)  pipe1 <= mem1[bus1.mem_addr_o[7:2]];
        if (bus3.mem_write_en_o) mem3[bus3.mem_addr_o[7:2]] <= bus3.mem_data_o;
        if (bus3.mem_read_en_o)  pipe3[0] <= mem3[bus3.mem_addr_o[7:2]];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    // {i_gnt, d_gnt, i_rvalid, d_rvalid, read_en, write_en}
    function automatic logic [5:0] st1();
        return {bus1.i_gnt_o, bus1.d_gnt_o, bus1.i_rvalid_o, bus1.d_rvalid_o,
                bus1.mem_read_en_o, bus1.mem_write_en_o};
    endfunction

    function automatic logic [5:0] st3();
        return {bus3.i_gnt_o, bus3.d_gnt_o, bus3.i_rvalid_o, bus3.d_rvalid_o,
                bus3.mem_read_en_o, bus3.mem_write_en_o};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        bus1.i_req_i   = 1'b1;
        bus1.i_addr_i  = 32'h0100_0000;
        bus1.d_req_i   = 1'b1;
        bus1.d_we_i    = 1'b1;
        bus1.d_addr_i  = 32'h0100_0020;
        bus1.d_wdata_i = 32'h1234_5678;
        #1;
        checks++;
        if (st1() !== 6'b000000) begin
            errors++; $display("FAIL reset_status: got %b expected %b", st1(), 6'b000000);
        end
        checks++;
        if ({bus1.i_rdata_o, bus1.d_rdata_o} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h %h expected 0 0", bus1.i_rdata_o, bus1.d_rdata_o);
        end
        checks++;
        if ({bus1.mem_addr_o, bus1.mem_data_o} !== 64'h0) begin
            errors++; $display("FAIL reset_mem_bus: got %h %h expected 0 0", bus1.mem_addr_o, bus1.mem_data_o);
        end
        @(negedge clk);
        rst1 = 1'b1;
        rst3 = 1'b1;
        #1;
        checks++;
        if (st1() !== 6'b010001) begin
            errors++; $display("FAIL release_dgnt: got %b expected %b", st1(), 6'b010001);
        end
        checks++;
        if ({bus1.mem_addr_o, bus1.mem_data_o} !== {32'h0100_0020, 32'h1234_5678}) begin
            errors++; $display("FAIL release_mem_bus: got %h %h expected 01000020 12345678", bus1.mem_addr_o, bus1.mem_data_o);
        end
        @(negedge clk);
        bus1.i_req_i = 1'b0;
        bus1.d_req_i = 1'b0;
        bus1.d_we_i  = 1'b0;
    endtask

    task automatic test_fetch();
        logic [5:0] exp_st [0:4];
        exp_st = '{6'b100010, 6'b101010, 6'b101010, 6'b001000, 6'b000000};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus1.i_req_i  = (k < 3);
            bus1.i_addr_i = 32'h0100_0000 + 32'(4 * k);
            #1;
            checks++;
            if (st1() !== exp_st[k]) begin
                errors++; $display("FAIL fetch_status[%0d]: got %b expected %b", k, st1(), exp_st[k]);
            end
            if (k < 3) begin
                checks++;
                if (bus1.mem_addr_o !== 32'h0100_0000 + 32'(4 * k)) begin
                    errors++; $display("FAIL fetch_addr[%0d]: got %h expected %h", k, bus1.mem_addr_o, 32'h0100_0000 + 32'(4 * k));
                end
            end
            if (k >= 1 && k <= 3) begin
                checks++;
                if (bus1.i_rdata_o !== (32'hF00D_0000 | 32'(k - 1))) begin
                    errors++; $display("FAIL fetch_rdata[%0d]: got %h expected %h", k, bus1.i_rdata_o, 32'hF00D_0000 | 32'(k - 1));
                end
            end
        end
        bus1.i_req_i = 1'b0;
    endtask

    task automatic test_starve();
        logic [5:0] exp;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus1.i_req_i   = 1'b1;
            bus1.i_addr_i  = 32'h0100_0000;
            bus1.d_req_i   = 1'b1;
            bus1.d_we_i    = 1'b1;
            bus1.d_addr_i  = 32'h0100_0024;
            bus1.d_wdata_i = 32'h0000_0100 + 32'(c);
            #1;
            if (c % 5 == 4)  exp = 6'b100010;
            else if (c == 5) exp = 6'b011001;
            else             exp = 6'b010001;
            checks++;
            if (st1() !== exp) begin
                errors++; $display("FAIL starve_status[%0d]: got %b expected %b", c, st1(), exp);
            end
        end
        @(negedge clk);
        bus1.i_req_i = 1'b0;
        bus1.d_req_i = 1'b0;
        bus1.d_we_i  = 1'b0;
    endtask

    task automatic test_lat3();
        logic [5:0] exp_st [0:8];
        exp_st = '{6'b010010, 6'b000000, 6'b000000, 6'b010101, 6'b010010,
                   6'b000000, 6'b000000, 6'b000100, 6'b000000};
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            case (t)
                0: begin
                    bus3.d_req_i = 1'b1; bus3.d_we_i = 1'b0; bus3.d_addr_i = 32'h0100_0010;
                end
                1: begin
                    bus3.d_we_i = 1'b1; bus3.d_addr_i = 32'h0100_0014; bus3.d_wdata_i = 32'hDEAD_BEEF;
                end
                4: begin
                    bus3.d_we_i = 1'b0; bus3.d_addr_i = 32'h0100_0014;
                end
                5: bus3.d_req_i = 1'b0;
                default: ;
            endcase
            #1;
            checks++;
            if (st3() !== exp_st[t]) begin
                errors++; $display("FAIL lat3_status[T+%0d]: got %b expected %b", t, st3(), exp_st[t]);
            end
            if (t == 3) begin
                checks++;
                if (bus3.d_rdata_o !== 32'hBEEF_0004) begin
                    errors++; $display("FAIL lat3_read_data: got %h expected beef0004", bus3.d_rdata_o);
                end
                checks++;
                if (bus3.mem_data_o !== 32'hDEAD_BEEF) begin
                    errors++; $display("FAIL lat3_write_data: got %h expected deadbeef", bus3.mem_data_o);
                end
            end
            if (t == 7) begin
                checks++;
                if (bus3.d_rdata_o !== 32'hDEAD_BEEF) begin
                    errors++; $display("FAIL lat3_readback: got %h expected deadbeef", bus3.d_rdata_o);
                end
            end
        end
    endtask

    task automatic test_reset_pending();
        logic [5:0] exp_st [0:4];
        exp_st = '{6'b100010, 6'b000000, 6'b010001, 6'b000000, 6'b000000};
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            case (t)
                0: begin
                    bus3.i_req_i = 1'b1; bus3.i_addr_i = 32'h0100_0008;
                end
                1: begin
                    bus3.i_req_i = 1'b0; rst3 = 1'b0;
                end
                2: begin
                    rst3 = 1'b1;
                    bus3.d_req_i = 1'b1; bus3.d_we_i = 1'b1;
                    bus3.d_addr_i = 32'h0100_0018; bus3.d_wdata_i = 32'h55AA_55AA;
                end
                3: begin
                    bus3.d_req_i = 1'b0; bus3.d_we_i = 1'b0;
                end
                default: ;
            endcase
            #1;
            checks++;
            if (st3() !== exp_st[t]) begin
                errors++; $display("FAIL rstpend_status[T+%0d]: got %b expected %b", t, st3(), exp_st[t]);
            end
            if (t == 1) begin
                checks++;
                if (bus3.i_rdata_o !== 32'h0) begin
                    errors++; $display("FAIL rstpend_rdata: got %h expected 0", bus3.i_rdata_o);
                end
            end
        end
    endtask

    initial begin
        clk    = 1'b0;
        rst1   = 1'b0;
        rst3   = 1'b0;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) begin
            mem1[i] = 32'hF00D_0000 | 32'(i);
            mem3[i] = 32'hBEEF_0000 | 32'(i);
        end
        bus1.i_req_i = 1'b0; bus1.i_addr_i = '0;
        bus1.d_req_i = 1'b0; bus1.d_we_i = 1'b0; bus1.d_addr_i = '0; bus1.d_wdata_i = '0;
        bus3.i_req_i = 1'b0; bus3.i_addr_i = '0;
        bus3.d_req_i = 1'b0; bus3.d_we_i = 1'b0; bus3.d_addr_i = '0; bus3.d_wdata_i = '0;

        test_reset();
        test_fetch();
        test_starve();
        test_lat3();
        test_reset_pending();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
